// File: rtl/speed_level_ctrl_if.sv
// Control/status bundle between the game FSM/score logic and the speed scheduler.
// Signal prefixes are from the scheduler's point of view (i_ into it, o_ out of it).
interface speed_level_ctrl_if;
  logic       i_start;
  logic       i_pause;
  logic       i_game_over;
  logic       i_score_evt;
  logic       i_ovr_en;
  logic [3:0] i_ovr_level;
  logic       i_div_clk;
  logic [3:0] o_level;
  logic       o_tick;
  logic       o_level_up;
  logic [1:0] o_state;

  modport master (
    output i_start, i_pause, i_game_over, i_score_evt, i_ovr_en, i_ovr_level, i_div_clk,
    input  o_level, o_tick, o_level_up, o_state
  );

  modport slave (
    input  i_start, i_pause, i_game_over, i_score_evt, i_ovr_en, i_ovr_level, i_div_clk,
    output o_level, o_tick, o_level_up, o_state
  );
endinterface

// File: rtl/speed_level_ctrl.sv
// Game-speed scheduler: picks the clock divider level from game state and score
// progress, and turns the divided clock into a masked single-cycle tick.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no game; slowest level driven, waits for start
// ST_RUN   | game running; score events advance the level, ticks pass
// ST_PAUSE | game held; score events and divider edges are dropped
// ST_OVER  | game ended; slowest level driven, waits for restart
module speed_level_ctrl #(
  parameter logic [3:0] IDLE_LEVEL     = 4'd0,
  parameter logic [3:0] START_LEVEL    = 4'd3,
  parameter logic [3:0] MAX_LEVEL      = 4'd12,
  parameter int         EVTS_PER_LEVEL = 8,
  parameter int         LOCK_CYC       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  speed_level_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int EW = (EVTS_PER_LEVEL > 1) ? $clog2(EVTS_PER_LEVEL) : 1;
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam logic [EW-1:0] EVT_LAST  = EW'(EVTS_PER_LEVEL - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC);

  logic [1:0]    r_state;
  logic [3:0]    r_int_level;
  logic [EW-1:0] r_evt_cnt;
  logic [LW-1:0] r_lock_cnt;
  logic          r_div_clk_q;
  logic [3:0]    r_level;
  logic          r_tick;
  logic          r_level_up;

  logic [1:0]    w_state_nxt;
  logic [3:0]    w_int_level_nxt;
  logic [EW-1:0] w_evt_cnt_nxt;
  logic          w_level_up_nxt;
  logic [3:0]    w_level_nxt;
  logic          w_div_rise;

  assign w_div_rise = bus.i_div_clk & ~r_div_clk_q;

  // Next game state, score progress and the level the divider should see next.
  always_comb begin
    w_state_nxt     = r_state;
    w_int_level_nxt = r_int_level;
    w_evt_cnt_nxt   = r_evt_cnt;
    w_level_up_nxt  = 1'b0;
    w_level_nxt     = r_level;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (bus.i_start) begin
          w_state_nxt     = ST_RUN;
          w_int_level_nxt = START_LEVEL;
          w_evt_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (bus.i_game_over) begin
          w_state_nxt = ST_OVER;
        end else if (bus.i_pause) begin
          w_state_nxt = ST_PAUSE;
        end else if (bus.i_score_evt) begin
          if (r_evt_cnt == EVT_LAST) begin
            w_evt_cnt_nxt = '0;
            if (r_int_level < MAX_LEVEL) begin
              w_int_level_nxt = r_int_level + 4'd1;
              w_level_up_nxt  = 1'b1;
            end
          end else begin
            w_evt_cnt_nxt = r_evt_cnt + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.i_game_over) begin
          w_state_nxt = ST_OVER;
        end else if (!bus.i_pause) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Override is a pure output mux; scoring keeps advancing underneath it.
    if (bus.i_ovr_en) begin
      w_level_nxt = bus.i_ovr_level;
    end else if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_OVER)) begin
      w_level_nxt = IDLE_LEVEL;
    end else begin
      w_level_nxt = w_int_level_nxt;
    end
  end

  // State, scoring and level registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_int_level <= START_LEVEL;
      r_evt_cnt   <= '0;
      r_level     <= IDLE_LEVEL;
      r_level_up  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_int_level <= w_int_level_nxt;
      r_evt_cnt   <= w_evt_cnt_nxt;
      r_level     <= w_level_nxt;
      r_level_up  <= w_level_up_nxt;
    end
  end

  // Reload lockout: restarts on every level change so ticks stay masked while the divider reloads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
    end else if (w_level_nxt != r_level) begin
      r_lock_cnt <= LOCK_LOAD;
    end else if (r_lock_cnt != '0) begin
      r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  // Tick on a divider rising edge while running and unlocked; masked edges are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_clk_q <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_div_clk_q <= bus.i_div_clk;
      r_tick      <= w_div_rise & (r_state == ST_RUN) & (r_lock_cnt == '0);
    end
  end

  assign bus.o_state    = r_state;
  assign bus.o_level    = r_level;
  assign bus.o_tick     = r_tick;
  assign bus.o_level_up = r_level_up;

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Directed bench for speed_level_ctrl; expectations go through a scoreboard queue.
module tb_speed_level_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  speed_level_ctrl_if bus();

  speed_level_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [3:0] lvl;
    logic       tk;
    logic       lu;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [1:0] st, input logic [3:0] lvl,
                      input logic tk, input logic lu);
    exp_t e;
    e.tag = tag; e.st = st; e.lvl = lvl; e.tk = tk; e.lu = lu;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty: got size=%0d need>0", exp_q.size());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (bus.o_state === e.st) else begin
        failures++;
        $error("FAIL %s state: got=%0d exp=%0d", e.tag, bus.o_state, e.st);
      end
      checks++;
      assert (bus.o_level === e.lvl) else begin
        failures++;
        $error("FAIL %s level: got=%0d exp=%0d", e.tag, bus.o_level, e.lvl);
      end
      checks++;
      assert (bus.o_tick === e.tk) else begin
        failures++;
        $error("FAIL %s tick: got=%0b exp=%0b", e.tag, bus.o_tick, e.tk);
      end
      checks++;
      assert (bus.o_level_up === e.lu) else begin
        failures++;
        $error("FAIL %s level_up: got=%0b exp=%0b", e.tag, bus.o_level_up, e.lu);
      end
    end
  endtask

  // One clock with the inputs currently driven; outputs sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic [1:0] st, input logic [3:0] lvl,
                      input logic tk, input logic lu);
    push(tag, st, lvl, tk, lu);
    @(posedge clk);
    #1;
    compare();
  endtask

  int   m_lvl;
  int   m_cnt;
  logic m_lu;

  initial begin
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_pause     = 1'b0;
    bus.i_game_over = 1'b0;
    bus.i_score_evt = 1'b0;
    bus.i_ovr_en    = 1'b0;
    bus.i_ovr_level = 4'd0;
    bus.i_div_clk   = 1'b0;

    // Reset
    step("rst0", 2'd0, 4'd0, 1'b0, 1'b0);
    step("rst1", 2'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // IDLE ignores everything but start
    bus.i_game_over = 1'b1; bus.i_pause = 1'b1; bus.i_score_evt = 1'b1; bus.i_div_clk = 1'b1;
    step("idle_ign", 2'd0, 4'd0, 1'b0, 1'b0);
    bus.i_game_over = 1'b0; bus.i_pause = 1'b0; bus.i_score_evt = 1'b0; bus.i_div_clk = 1'b0;
    step("idle_ign2", 2'd0, 4'd0, 1'b0, 1'b0);

    // Start, then 8 score events -> 3 to 4
    bus.i_start = 1'b1;
    step("start", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_start = 1'b0;
    bus.i_score_evt = 1'b1;
    for (int i = 0; i < 8; i++)
      step("evt_l4", 2'd1, (i == 7) ? 4'd4 : 4'd3, 1'b0, (i == 7));
    bus.i_score_evt = 1'b0;

    // Edge inside the lockout is dropped; a later edge ticks once
    bus.i_div_clk = 1'b1;
    step("lock_mask", 2'd1, 4'd4, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0;
    for (int i = 0; i < 3; i++) step("lock_wait", 2'd1, 4'd4, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1;
    step("tick_ok", 2'd1, 4'd4, 1'b1, 1'b0);
    step("tick_once", 2'd1, 4'd4, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0;
    step("tick_low", 2'd1, 4'd4, 1'b0, 1'b0);

    // GameOver with simultaneous ScoreEvt at EvtCnt=7
    bus.i_score_evt = 1'b1;
    for (int i = 0; i < 7; i++) step("evt_pre_go", 2'd1, 4'd4, 1'b0, 1'b0);
    bus.i_game_over = 1'b1;
    step("go_evt", 2'd3, 4'd0, 1'b0, 1'b0);
    bus.i_game_over = 1'b0; bus.i_pause = 1'b1;
    step("over_hold", 2'd3, 4'd0, 1'b0, 1'b0);
    bus.i_pause = 1'b0; bus.i_score_evt = 1'b0; bus.i_start = 1'b1;
    step("restart", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_start = 1'b0;

    // Pause holds EvtCnt and drops divider edges
    bus.i_score_evt = 1'b1;
    for (int i = 0; i < 4; i++) step("evt_pre_pause", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_score_evt = 1'b0; bus.i_pause = 1'b1;
    step("pause_in", 2'd2, 4'd3, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1; bus.i_score_evt = 1'b1;
    step("pause_dc1", 2'd2, 4'd3, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0;
    step("pause_dc0", 2'd2, 4'd3, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1; bus.i_score_evt = 1'b0;
    step("pause_dc1b", 2'd2, 4'd3, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0;
    step("pause_dc0b", 2'd2, 4'd3, 1'b0, 1'b0);
    bus.i_pause = 1'b0;
    step("unpause", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1;
    step("tick_resume", 2'd1, 4'd3, 1'b1, 1'b0);
    bus.i_div_clk = 1'b0;
    step("tick_resume_lo", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_score_evt = 1'b1;
    for (int i = 0; i < 4; i++)
      step("evt_held_cnt", 2'd1, (i == 3) ? 4'd4 : 4'd3, 1'b0, (i == 3));
    for (int i = 0; i < 8; i++)
      step("evt_l5", 2'd1, (i == 7) ? 4'd5 : 4'd4, 1'b0, (i == 7));
    bus.i_score_evt = 1'b0;

    // Override to 15 at level 5; internal level keeps advancing underneath
    bus.i_ovr_en = 1'b1; bus.i_ovr_level = 4'd15;
    step("ovr_on", 2'd1, 4'd15, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1;
    step("ovr_mask", 2'd1, 4'd15, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0; bus.i_score_evt = 1'b1;
    for (int i = 0; i < 8; i++) step("ovr_evt", 2'd1, 4'd15, 1'b0, (i == 7));
    bus.i_score_evt = 1'b0; bus.i_ovr_en = 1'b0;
    step("ovr_off", 2'd1, 4'd6, 1'b0, 1'b0);
    bus.i_div_clk = 1'b1;
    step("ovr_off_mask", 2'd1, 4'd6, 1'b0, 1'b0);
    bus.i_div_clk = 1'b0;

    // Advance to MAX_LEVEL and keep scoring: level saturates, no LevelUp
    m_lvl = 6; m_cnt = 0;
    bus.i_score_evt = 1'b1;
    for (int i = 0; i < 56; i++) begin
      m_lu = 1'b0;
      if (m_cnt == 7) begin
        m_cnt = 0;
        if (m_lvl < 12) begin
          m_lvl++;
          m_lu = 1'b1;
        end
      end else begin
        m_cnt++;
      end
      step("evt_sat", 2'd1, 4'(m_lvl), 1'b0, m_lu);
    end
    bus.i_score_evt = 1'b0;

    // Reset mid-game, then a fresh start comes up at START_LEVEL
    rst = 1'b1;
    step("rst_mid0", 2'd0, 4'd0, 1'b0, 1'b0);
    step("rst_mid1", 2'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.i_start = 1'b1;
    step("post_rst_start", 2'd1, 4'd3, 1'b0, 1'b0);
    bus.i_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speed_level_ctrl.md
Name: speed_level_ctrl

Overview:
- Game-speed scheduler that sequences the modulated clock divider.
- Picks the divider's 4-bit level select from game state and score progress, with a manual switch override.
- Turns the divided clock into a single-cycle Tick enable for game logic.
- Masks ticks while the divider reloads after a level change. Sits between the game FSM/score logic and the divider.

Parameters:
- IDLE_LEVEL, 0, level driven in IDLE/OVER (slowest speed)
- START_LEVEL, 3, level loaded on Start
- MAX_LEVEL, 12, saturation level for automatic advance
- EVTS_PER_LEVEL, 8, ScoreEvt pulses per level advance (>=1)
- LOCK_CYC, 4, Clk cycles Tick is masked after any Level output change (>=3; divider reload takes 3 cycles)

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- Start  in  1  level; begin/restart game
- Pause  in  1  level; hold game
- GameOver  in  1  level/pulse; end game
- ScoreEvt  in  1  single-cycle score pulse
- OvrEn  in  1  manual level override enable
- OvrLevel  in  4  manual level value
- DivClk  in  1  divider output clock, registered in Clk domain
- Level  out  4  registered level select to divider
- Tick  out  1  single-cycle game-step enable
- LevelUp  out  1  single-cycle pulse on automatic advance
- State  out  2  0=IDLE 1=RUN 2=PAUSE 3=OVER

Behaviour:
- All outputs registered.
- Reset values: State=IDLE, Level=IDLE_LEVEL, Tick=0, LevelUp=0, internal level=START_LEVEL, EvtCnt=0, LockCnt=0, DivClk_q=0.
- Rst has priority over everything and is honoured mid-game.
- IDLE:
  - Start -> RUN; internal level <= START_LEVEL; EvtCnt <= 0.
  - GameOver, Pause and ScoreEvt are ignored.
- RUN (priority GameOver > Pause > ScoreEvt):
  - GameOver -> OVER; a simultaneous ScoreEvt is discarded.
  - Pause -> PAUSE.
  - ScoreEvt with EvtCnt < EVTS_PER_LEVEL-1: EvtCnt+1.
  - ScoreEvt with EvtCnt == EVTS_PER_LEVEL-1: EvtCnt <= 0. If internal level < MAX_LEVEL, level +1 and LevelUp=1 for one cycle; otherwise level holds and LevelUp stays 0.
- PAUSE:
  - ScoreEvt ignored; EvtCnt and level held.
  - GameOver -> OVER; Pause low -> RUN.
- OVER:
  - Start -> RUN with internal level <= START_LEVEL and EvtCnt <= 0; otherwise stay.
- Level output:
  - Level <= OvrEn ? OvrLevel : (State in IDLE/OVER next ? IDLE_LEVEL : internal level).
  - Updated on the edge after the causing input, in the same cycle as LevelUp.
  - Override does not stop EvtCnt or the internal level from advancing.
  - Override values are not clamped; any 0-15 is passed through.
- Lockout:
  - Whenever next Level != current Level, LockCnt <= LOCK_CYC.
  - Otherwise LockCnt decrements to 0 and saturates.
- Tick:
  - DivClk_q holds last cycle's DivClk.
  - Rising edge = DivClk & ~DivClk_q.
  - Tick <= rising edge & (State==RUN) & (LockCnt==0); one cycle after the edge is sampled.
  - Never high two consecutive cycles.
  - DivClk edges during PAUSE or lockout are dropped, not queued.
- State changes take effect on the next Clk edge; no combinational path from inputs to outputs.
- Level stays 4 bits. Internal level arithmetic saturates at MAX_LEVEL; no wrap to 0.

Test Plan:
- Rst=1 for 2 cycles mid-RUN at level 7 -> State=0, Level=0, Tick=0, LevelUp=0 on the following cycle.
- Start, then 8 ScoreEvt pulses -> Level goes 3->4 one cycle after the 8th pulse with a one-cycle LevelUp. Next DivClk edge within 4 cycles gives no Tick; a later edge gives Tick one cycle after the edge.
- Run to level 12, then 8 more ScoreEvt -> Level stays 12, LevelUp never asserts, EvtCnt returns to 0.
- Pause=1 while DivClk toggles and ScoreEvt pulses -> no Tick, Level unchanged. Pause=0 -> Tick resumes on the next DivClk edge after lockout; EvtCnt counts from its held value.
- GameOver and ScoreEvt in the same cycle at EvtCnt=7 -> State=3, Level=0, no LevelUp. Start -> State=1, Level=3.
- OvrEn=1, OvrLevel=15 in RUN at level 5 -> Level=15 next cycle, ticks masked 4 cycles. OvrEn=0 -> Level returns to the internal level (advanced if ScoreEvts occurred meanwhile).
